// File: rtl/gray_pkg.sv
// Shared definitions for the Gray step arbiter: FSM states, code width and
// the Gray successor function used by the stepper.
package gray_pkg;

    localparam int GRAY_W = 3;
    localparam logic [GRAY_W-1:0] GRAY_LAST = 3'b100;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Convert to binary, increment, convert back; wraps 100 -> 000.
    function automatic logic [GRAY_W-1:0] gray_next(input logic [GRAY_W-1:0] code);
        logic [GRAY_W-1:0] bin;
        logic [GRAY_W-1:0] inc;
        bin[GRAY_W-1] = code[GRAY_W-1];
        for (int i = GRAY_W - 2; i >= 0; i--) begin
            bin[i] = bin[i+1] ^ code[i];
        end
        inc = bin + 1'b1;
        return inc ^ (inc >> 1);
    endfunction

endpackage

// File: rtl/gray_stepper.sv
// 3-bit Gray register that advances once per enabled cycle, with a sticky
// overflow flag raised on the wrap back to 000.
module gray_stepper
    import gray_pkg::*;
(
    input  logic              Clk,
    input  logic              Reset,
    input  logic              En,
    input  logic              OvfClr,
    output logic [GRAY_W-1:0] Gray,
    output logic              Overflow
);

    logic [GRAY_W-1:0] gray_q, gray_d;
    logic              ovf_q, ovf_d;
    logic              wrap;

    always_ff @(posedge Clk) begin
        if (!Reset) begin
            gray_q <= '0;
            ovf_q  <= 1'b0;
        end else begin
            gray_q <= gray_d;
            ovf_q  <= ovf_d;
        end
    end

    // A wrap on the same cycle as a clear keeps the flag set.
    always_comb begin
        wrap   = En && (gray_q == GRAY_LAST);
        gray_d = En ? gray_next(gray_q) : gray_q;
        if (wrap) begin
            ovf_d = 1'b1;
        end else if (OvfClr) begin
            ovf_d = 1'b0;
        end else begin
            ovf_d = ovf_q;
        end
    end

    assign Gray     = gray_q;
    assign Overflow = ovf_q;

endmodule

// File: rtl/gray_step_arbiter.sv
// Round-robin arbiter granting bursts of Gray counter steps to one of two
// requesters at a time, pulsing a per-requester done at the end of each burst.
module gray_step_arbiter
    import gray_pkg::*;
#(
    parameter int LEN_W = 4
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic [1:0]        Req,
    input  logic [LEN_W-1:0]  Len0,
    input  logic [LEN_W-1:0]  Len1,
    input  logic              OvfClr,
    output logic [1:0]        Gnt,
    output logic              Busy,
    output logic [1:0]        Done,
    output logic [GRAY_W-1:0] Gray,
    output logic              Overflow
);

    state_t           state_q, state_d;
    logic [1:0]       gnt_q, gnt_d;
    logic [LEN_W-1:0] remain_q, remain_d;
    logic             last_q, last_d;
    logic             win;
    logic [LEN_W-1:0] len_sel;

    always_ff @(posedge Clk) begin
        if (!Reset) begin
            state_q  <= IDLE;
            gnt_q    <= 2'b00;
            remain_q <= '0;
            last_q   <= 1'b1;
        end else begin
            state_q  <= state_d;
            gnt_q    <= gnt_d;
            remain_q <= remain_d;
            last_q   <= last_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        gnt_d    = gnt_q;
        remain_d = remain_q;
        last_d   = last_q;
        // On a tie the requester not served last wins.
        win      = (Req == 2'b11) ? ~last_q : Req[1];
        len_sel  = win ? Len1 : Len0;
        case (state_q)
            IDLE: begin
                gnt_d = 2'b00;
                if (Req != 2'b00) begin
                    gnt_d    = win ? 2'b10 : 2'b01;
                    remain_d = len_sel;
                    state_d  = (len_sel != '0) ? RUN : DONE;
                end
            end
            RUN: begin
                if (remain_q != '0) begin
                    remain_d = remain_q - 1'b1;
                end
                if (remain_q <= 1) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                last_d  = gnt_q[1];
                gnt_d   = 2'b00;
                state_d = IDLE;
            end
            default: begin
                gnt_d   = 2'b00;
                state_d = IDLE;
            end
        endcase
    end

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_done
            assign Done[gi] = (state_q == DONE) && gnt_q[gi];
        end
    endgenerate

    assign Gnt  = gnt_q;
    assign Busy = (state_q != IDLE);

    gray_stepper u_stepper (
        .Clk      (Clk),
        .Reset    (Reset),
        .En       (state_q == RUN),
        .OvfClr   (OvfClr),
        .Gray     (Gray),
        .Overflow (Overflow)
    );

endmodule

// File: tb/tb_gray_step_arbiter.sv
// Scoreboard bench: stimulus predicts each burst outcome from a position-on-
// the-ring model and queues it; a monitor checks every Done pulse.
module tb_gray_step_arbiter;

    logic       Clk = 1'b0;
    logic       Reset = 1'b0;
    logic [1:0] Req = 2'b00;
    logic [3:0] Len0 = 4'd0;
    logic [3:0] Len1 = 4'd0;
    logic       OvfClr = 1'b0;
    logic [1:0] Gnt;
    logic       Busy;
    logic [1:0] Done;
    logic [2:0] Gray;
    logic       Overflow;

    gray_step_arbiter #(.LEN_W(4)) dut (
        .Clk(Clk), .Reset(Reset), .Req(Req), .Len0(Len0), .Len1(Len1),
        .OvfClr(OvfClr), .Gnt(Gnt), .Busy(Busy), .Done(Done),
        .Gray(Gray), .Overflow(Overflow)
    );

    always #5 Clk = ~Clk;

    typedef struct {
        int         idx;
        int         len;
        logic [2:0] gray;
        logic       ovf;
    } exp_t;

    exp_t q[$];
    int   vectors = 0;
    int   miscompares = 0;

    // Reference model: position 0..7 on the Gray ring, sticky flag, last served.
    int   m_pos = 0;
    logic m_ovf = 1'b0;
    int   m_last = 1;

    function automatic logic [2:0] pos2gray(input int p);
        int g;
        g = p ^ (p >> 1);
        return g[2:0];
    endfunction

    function automatic logic [1:0] onehot(input int r);
        return (r == 0) ? 2'b01 : 2'b10;
    endfunction

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic predict(input int r, input int len, input bit clr);
        exp_t e;
        int   np;
        np = (m_pos + len) % 8;
        if (clr) begin
            m_ovf = (len > 0) && (np == 0);
        end else if (m_pos + len >= 8) begin
            m_ovf = 1'b1;
        end
        m_pos  = np;
        m_last = r;
        e.idx  = r;
        e.len  = len;
        e.gray = pos2gray(np);
        e.ovf  = m_ovf;
        q.push_back(e);
        $display("issue: req%0d len=%0d clr=%0d -> gray=%03b ovf=%0d", r, len, clr, e.gray, e.ovf);
    endtask

    task automatic wait_done(input int r, output bit ok);
        ok = 1'b0;
        for (int k = 0; k < 60; k++) begin
            @(negedge Clk);
            if (Done[r]) begin
                ok = 1'b1;
                return;
            end
        end
        vectors++;
        miscompares++;
        $display("FAIL timeout: Done[%0d] got 0 expected 1 within 60 cycles", r);
    endtask

    task automatic do_reset();
        @(negedge Clk);
        Reset = 1'b0;
        Req = 2'b00;
        OvfClr = 1'b0;
        repeat (2) @(negedge Clk);
        m_pos = 0;
        m_ovf = 1'b0;
        m_last = 1;
        chk("rst_gray", {13'd0, Gray}, 16'd0);
        chk("rst_gnt", {14'd0, Gnt}, 16'd0);
        chk("rst_done", {14'd0, Done}, 16'd0);
        chk("rst_busy", {15'd0, Busy}, 16'd0);
        chk("rst_ovf", {15'd0, Overflow}, 16'd0);
        Reset = 1'b1;
    endtask

    task automatic run_single(input int r, input int len, input bit clr);
        bit ok;
        predict(r, len, clr);
        @(negedge Clk);
        if (r == 0) Len0 = len[3:0]; else Len1 = len[3:0];
        OvfClr = clr;
        Req = onehot(r);
        @(posedge Clk);
        #1;
        chk("grant_latency", {14'd0, Gnt}, {14'd0, onehot(r)});
        // Len is only sampled at grant; scramble it afterwards.
        Len0 = 4'($urandom);
        Len1 = 4'($urandom);
        wait_done(r, ok);
        Req = 2'b00;
        OvfClr = 1'b0;
    endtask

    task automatic run_pair(input int l0, input int l1);
        bit ok;
        int first, second;
        first  = (m_last == 1) ? 0 : 1;
        second = 1 - first;
        predict(first, (first == 0) ? l0 : l1, 1'b0);
        predict(second, (second == 0) ? l0 : l1, 1'b0);
        @(negedge Clk);
        Len0 = l0[3:0];
        Len1 = l1[3:0];
        Req = 2'b11;
        @(posedge Clk);
        #1;
        chk("pair_first", {14'd0, Gnt}, {14'd0, onehot(first)});
        wait_done(first, ok);
        Req[first] = 1'b0;
        wait_done(second, ok);
        Req = 2'b00;
    endtask

    task automatic run_cont(input int n, input int l0, input int l1);
        bit ok;
        int who;
        who = (m_last == 1) ? 0 : 1;
        for (int k = 0; k < n; k++) begin
            predict(who, (who == 0) ? l0 : l1, 1'b0);
            who = 1 - who;
        end
        @(negedge Clk);
        Len0 = l0[3:0];
        Len1 = l1[3:0];
        Req = 2'b11;
        who = (m_last == 1) ? 1 : 0;
        // m_last now names the final winner; recompute the first.
        who = (n % 2 == 0) ? 1 - m_last : m_last;
        for (int k = 0; k < n; k++) begin
            wait_done(who, ok);
            if (k == n - 1) Req = 2'b00;
            who = 1 - who;
        end
    endtask

    task automatic idle_clear();
        @(negedge Clk);
        OvfClr = 1'b1;
        @(posedge Clk);
        #1;
        OvfClr = 1'b0;
        m_ovf = 1'b0;
        chk("ovfclr_alone", {15'd0, Overflow}, 16'd0);
    endtask

    task automatic abort_test();
        @(negedge Clk);
        Len0 = 4'd7;
        Req = 2'b01;
        repeat (3) @(posedge Clk);
        @(negedge Clk);
        chk("abort_pre_gray", {13'd0, Gray}, {13'd0, pos2gray(m_pos + 2)});
        Reset = 1'b0;
        Req = 2'b00;
        @(posedge Clk);
        #1;
        m_pos = 0;
        m_ovf = 1'b0;
        m_last = 1;
        chk("abort_gray", {13'd0, Gray}, 16'd0);
        chk("abort_gnt", {14'd0, Gnt}, 16'd0);
        chk("abort_busy", {15'd0, Busy}, 16'd0);
        chk("abort_done", {14'd0, Done}, 16'd0);
        @(negedge Clk);
        Reset = 1'b1;
    endtask

    // Monitor: checks each Done pulse against the queue and the cycle after it.
    initial begin
        int  busy_cnt;
        bit  post_done;
        exp_t e;
        busy_cnt = 0;
        post_done = 1'b0;
        forever begin
            @(negedge Clk);
            if (post_done) begin
                chk("done_width", {14'd0, Done}, 16'd0);
                chk("gnt_drop", {14'd0, Gnt}, 16'd0);
                chk("busy_drop", {15'd0, Busy}, 16'd0);
                post_done = 1'b0;
            end
            busy_cnt = Busy ? busy_cnt + 1 : 0;
            if (Done != 2'b00) begin
                if (q.size() == 0) begin
                    vectors++;
                    miscompares++;
                    $display("FAIL unexpected_done: got %02b expected none", Done);
                end else begin
                    e = q.pop_front();
                    chk("done_bit", {14'd0, Done}, {14'd0, onehot(e.idx)});
                    chk("done_gnt", {14'd0, Gnt}, {14'd0, onehot(e.idx)});
                    chk("done_gray", {13'd0, Gray}, {13'd0, e.gray});
                    chk("done_ovf", {15'd0, Overflow}, {15'd0, e.ovf});
                    chk("burst_cycles", 16'(busy_cnt), 16'(e.len + 1));
                    $display("done: req%0d len=%0d gray=%03b ovf=%0d cycles=%0d",
                             e.idx, e.len, Gray, Overflow, busy_cnt);
                end
                post_done = 1'b1;
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int kind;
        do_reset();
        run_single(0, 3, 1'b0);
        do_reset();
        run_pair(2, 1);
        run_cont(4, 1, 1);
        do_reset();
        run_single(0, 8, 1'b0);
        run_single(1, 8, 1'b1);
        idle_clear();
        run_single(1, 0, 1'b0);
        do_reset();
        abort_test();
        for (int n = 0; n < 60; n++) begin
            kind = $urandom_range(0, 9);
            if (kind < 5) begin
                run_single($urandom_range(0, 1), $urandom_range(0, 15), 1'($urandom_range(0, 1)));
            end else if (kind < 8) begin
                run_pair($urandom_range(0, 15), $urandom_range(0, 15));
            end else if (kind == 8) begin
                run_cont($urandom_range(2, 4), $urandom_range(0, 6), $urandom_range(0, 6));
            end else begin
                idle_clear();
            end
            repeat ($urandom_range(0, 2)) @(negedge Clk);
        end
        repeat (4) @(negedge Clk);
        chk("queue_empty", 16'(q.size()), 16'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
